// File: rtl/attn_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : attn_pkg
//  Purpose : Shared sizing constants, derived-width helpers and the
//            serializer state encoding.
//  Ports   : none (package)
//  Revision: 1.0  initial release
// ============================================================================
package attn_pkg;

   localparam int c_WIDTH_OUT     = 16;
   localparam int c_WIDTH_Q       = 8;
   localparam int c_CHUNK_SIZE    = 4;
   localparam int c_NUM_CORES_A   = 4;
   localparam int c_NUM_CORES_B   = 1;
   localparam int c_TOTAL_MODULES = 2;
   localparam int c_TOTAL_INPUT_W = 2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Elements carried by one vector across all cores and module replicas.
   function automatic int calc_elems(input int chunk, input int cores_a,
                                     input int cores_b, input int modules);
      return chunk * cores_a * cores_b * modules;
   endfunction

   // Flat bit width of one vector of elems elements, each width bits wide.
   function automatic int calc_vector_bits(input int width, input int elems);
      return width * elems;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_clip.sv
`default_nettype none
// ============================================================================
//  Module  : sat_clip
//  Purpose : Combinational signed saturation of one element from WIDTH_IN
//            bits down to WIDTH_Q bits, with a flag raised when clipped.
//  Ports   : din  [WIDTH_IN-1:0] signed element in
//            dout [WIDTH_Q-1:0]  saturated element out
//            clip                element was outside the WIDTH_Q range
//  Revision: 1.0  initial release
// ============================================================================
module sat_clip #(
   parameter int WIDTH_IN = 16,
   parameter int WIDTH_Q  = 8
) (
   input  logic [WIDTH_IN-1:0] din,
   output logic [WIDTH_Q-1:0]  dout,
   output logic                clip
);

   // Range bounds expressed at the input width so the compare is exact.
   localparam logic signed [WIDTH_IN-1:0] c_MAX = WIDTH_IN'((1 << (WIDTH_Q - 1)) - 1);
   localparam logic signed [WIDTH_IN-1:0] c_MIN = ~c_MAX;

   logic signed [WIDTH_IN-1:0] w_din;

   assign w_din = $signed(din);

   always_comb begin
      dout = w_din[WIDTH_Q-1:0];
      clip = 1'b0;
      if (w_din > c_MAX) begin
         dout = c_MAX[WIDTH_Q-1:0];
         clip = 1'b1;
      end else if (w_din < c_MIN) begin
         dout = c_MIN[WIDTH_Q-1:0];
         clip = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/rshift_serializer.sv
`default_nettype none
// ============================================================================
//  Module  : rshift_serializer
//  Purpose : Accepts a beat of TOTAL_INPUT_W shifted vectors, saturates every
//            element to WIDTH_Q bits and replays the vectors one word at a
//            time over a valid/ready output, with a back-to-back load path.
//  Ports   : clk, rst                 clock, synchronous active-high reset
//            in_valid / in_ready      input beat handshake
//            in_shifted[w]            VECTOR_BITS vectors, element 0 at MSB
//            out_valid / out_ready    output word handshake
//            out_data                 QBITS saturated vector
//            out_idx, out_last        word index / final word of the beat
//            out_sat                  some element of this word was clipped
//  Revision: 1.0  initial release
// ============================================================================
module rshift_serializer
   import attn_pkg::*;
#(
   parameter  int WIDTH_OUT     = c_WIDTH_OUT,
   parameter  int WIDTH_Q       = c_WIDTH_Q,
   parameter  int CHUNK_SIZE    = c_CHUNK_SIZE,
   parameter  int NUM_CORES_A   = c_NUM_CORES_A,
   parameter  int NUM_CORES_B   = c_NUM_CORES_B,
   parameter  int TOTAL_MODULES = c_TOTAL_MODULES,
   parameter  int TOTAL_INPUT_W = c_TOTAL_INPUT_W,
   localparam int ELEMS         = calc_elems(CHUNK_SIZE, NUM_CORES_A, NUM_CORES_B, TOTAL_MODULES),
   localparam int VECTOR_BITS   = calc_vector_bits(WIDTH_OUT, ELEMS),
   localparam int QBITS         = calc_vector_bits(WIDTH_Q, ELEMS),
   localparam int IDX_W         = (TOTAL_INPUT_W > 1) ? $clog2(TOTAL_INPUT_W) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [VECTOR_BITS-1:0] in_shifted [TOTAL_INPUT_W],
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [QBITS-1:0]       out_data,
   output logic [IDX_W-1:0]       out_idx,
   output logic                   out_last,
   output logic                   out_sat
);

   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(TOTAL_INPUT_W - 1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [IDX_W-1:0]       r_idx;
   logic [IDX_W-1:0]       w_idx_nxt;
   logic [QBITS-1:0]       r_words [TOTAL_INPUT_W];
   logic [TOTAL_INPUT_W-1:0] r_sat;

   logic [WIDTH_Q-1:0]     w_q      [TOTAL_INPUT_W][ELEMS];
   logic                   w_clip   [TOTAL_INPUT_W][ELEMS];
   logic [QBITS-1:0]       w_packed [TOTAL_INPUT_W];
   logic [TOTAL_INPUT_W-1:0] w_word_sat;
   logic                   w_accept;
   logic                   w_out_hs;
   logic                   w_is_last;

   // ------------------------------------------------------------------
   // Saturation array: one clipper per element of every incoming vector
   // ------------------------------------------------------------------
   for (genvar w = 0; w < TOTAL_INPUT_W; w++) begin : g_word
      for (genvar e = 0; e < ELEMS; e++) begin : g_elem
         sat_clip #(
            .WIDTH_IN (WIDTH_OUT),
            .WIDTH_Q  (WIDTH_Q)
         ) u_sat_clip (
            .din  (in_shifted[w][VECTOR_BITS-1-e*WIDTH_OUT -: WIDTH_OUT]),
            .dout (w_q[w][e]),
            .clip (w_clip[w][e])
         );
      end
   end

   // Repack clipped elements MSB-first and fold clip flags per word.
   always_comb begin
      for (int w = 0; w < TOTAL_INPUT_W; w++) begin
         w_packed[w]   = '0;
         w_word_sat[w] = 1'b0;
         for (int e = 0; e < ELEMS; e++) begin
            w_packed[w][QBITS-1-e*WIDTH_Q -: WIDTH_Q] = w_q[w][e];
            w_word_sat[w] = w_word_sat[w] | w_clip[w][e];
         end
      end
   end

   // Word buffer: only the valid flag is reset; stale data is never visible
   // because the outputs are masked outside SEND.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int w = 0; w < TOTAL_INPUT_W; w++) begin
            r_words[w] <= w_packed[w];
         end
         r_sat <= w_word_sat;
      end
   end

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   assign w_is_last = (r_idx == c_LAST_IDX);

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      out_valid   = 1'b0;
      in_ready    = 1'b0;
      case (r_state)
         IDLE: in_ready = !rst;
         // Loading while the last word leaves keeps the output stream gapless.
         SEND: begin
            out_valid = 1'b1;
            in_ready  = !rst && w_is_last && out_ready;
         end
         default: ;
      endcase

      w_accept = in_valid && in_ready;
      w_out_hs = out_valid && out_ready;

      if (w_accept) begin
         w_state_nxt = SEND;
         w_idx_nxt   = '0;
      end else if (w_out_hs) begin
         if (w_is_last) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
         end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
         end
      end
   end

   assign out_idx  = r_idx;
   assign out_last = out_valid && w_is_last;
   assign out_data = out_valid ? r_words[r_idx] : '0;
   assign out_sat  = out_valid && r_sat[r_idx];

endmodule
`default_nettype wire

// File: tb/tb_rshift_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_rshift_serializer
//  Purpose : Self-checking bench for rshift_serializer (default sizing) with
//            a queue-based reference model of the saturated word stream.
//  Revision: 1.0  initial release
// ============================================================================
module tb_rshift_serializer;

   localparam int W     = 2;
   localparam int ELEMS = 32;
   localparam int WO    = 16;
   localparam int WQ    = 8;
   localparam int VB    = WO * ELEMS;
   localparam int QB    = WQ * ELEMS;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [VB-1:0] in_shifted [W];
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [QB-1:0] out_data;
   logic [0:0]    out_idx;
   logic          out_last;
   logic          out_sat;

   int checks = 0;
   int errors = 0;

   int vals [W][ELEMS];

   typedef struct {
      logic [QB-1:0] data;
      logic          sat;
      int            idx;
   } word_t;

   word_t exp_q [$];

   rshift_serializer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_shifted (in_shifted),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_idx    (out_idx),
      .out_last   (out_last),
      .out_sat    (out_sat)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   function automatic int sat_val(input int v);
      if (v > 127)  return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   function automatic logic [QB-1:0] model_word(input int w);
      logic [QB-1:0] r;
      int s;
      r = '0;
      for (int e = 0; e < ELEMS; e++) begin
         s = sat_val(vals[w][e]);
         r[QB-1-e*WQ -: WQ] = s[7:0];
      end
      return r;
   endfunction

   function automatic logic model_sat(input int w);
      logic s;
      s = 1'b0;
      for (int e = 0; e < ELEMS; e++)
         if (vals[w][e] != sat_val(vals[w][e])) s = 1'b1;
      return s;
   endfunction

   task automatic push_expected();
      word_t x;
      for (int w = 0; w < W; w++) begin
         x.data = model_word(w);
         x.sat  = model_sat(w);
         x.idx  = w;
         exp_q.push_back(x);
      end
   endtask

   task automatic drive_beat();
      for (int w = 0; w < W; w++)
         for (int e = 0; e < ELEMS; e++)
            in_shifted[w][VB-1-e*WO -: WO] = 16'(vals[w][e]);
   endtask

   task automatic rand_beat();
      logic signed [15:0] t;
      for (int w = 0; w < W; w++)
         for (int e = 0; e < ELEMS; e++) begin
            if ($urandom_range(0, 3) == 0) begin
               t = 16'($urandom);
               vals[w][e] = int'(t);
            end else begin
               vals[w][e] = int'($urandom_range(0, 400)) - 200;
            end
         end
      drive_beat();
   endtask

   // ------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (out_idx !== 1'b0)   begin errors++; $display("FAIL reset_idx: got %b want 0", out_idx); end
      checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL reset_last: got %b want 0", out_last); end
      checks++; if (out_sat !== 1'b0)   begin errors++; $display("FAIL reset_sat: got %b want 0", out_sat); end
      checks++; if (out_data !== '0)    begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_ramp();
      logic [QB-1:0] e0, e1;
      @(negedge clk);
      for (int w = 0; w < W; w++)
         for (int e = 0; e < ELEMS; e++) vals[w][e] = e * 4 - 64 + w;
      drive_beat();
      e0 = model_word(0); e1 = model_word(1);
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ramp_in_ready: got %b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1 || out_idx !== 1'b0 || out_last !== 1'b0 || out_sat !== 1'b0 || out_data !== e0) begin
         errors++; $display("FAIL ramp_word0: got v=%b idx=%0d last=%b sat=%b data=%h want v=1 idx=0 last=0 sat=0 data=%h", out_valid, out_idx, out_last, out_sat, out_data, e0);
      end
      checks++; if (out_data[QB-1 -: 8] !== 8'hC0) begin errors++; $display("FAIL ramp_elem0: got %h want c0", out_data[QB-1 -: 8]); end
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_idx !== 1'b1 || out_last !== 1'b1 || out_sat !== 1'b0 || out_data !== e1) begin
         errors++; $display("FAIL ramp_word1: got v=%b idx=%0d last=%b sat=%b data=%h want v=1 idx=1 last=1 sat=0 data=%h", out_valid, out_idx, out_last, out_sat, out_data, e1);
      end
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ramp_idle: got %b want 0", out_valid); end
   endtask

   task automatic test_saturation();
      int pat [6];
      pat = '{256, 32767, -256, -32768, 127, -128};
      @(negedge clk);
      for (int e = 0; e < ELEMS; e++) begin
         vals[0][e] = (e < 6) ? pat[e] : e;
         vals[1][e] = (e < 2) ? pat[e+4] : e - 10;
      end
      drive_beat();
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++; if (out_data[QB-1 -: 48] !== 48'h7F7F80807F80) begin errors++; $display("FAIL sat_word0_elems: got %h want 7f7f80807f80", out_data[QB-1 -: 48]); end
      checks++; if (out_sat !== 1'b1) begin errors++; $display("FAIL sat_word0_flag: got %b want 1", out_sat); end
      checks++; if (out_data !== model_word(0)) begin errors++; $display("FAIL sat_word0_data: got %h want %h", out_data, model_word(0)); end
      @(negedge clk); #1;
      checks++; if (out_data[QB-1 -: 16] !== 16'h7F80) begin errors++; $display("FAIL sat_word1_elems: got %h want 7f80", out_data[QB-1 -: 16]); end
      checks++; if (out_sat !== 1'b0 || out_last !== 1'b1) begin errors++; $display("FAIL sat_word1_flag: got sat=%b last=%b want sat=0 last=1", out_sat, out_last); end
      checks++; if (out_data !== model_word(1)) begin errors++; $display("FAIL sat_word1_data: got %h want %h", out_data, model_word(1)); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [QB-1:0] a0, a1, b0, b1;
      rand_beat();
      a0 = model_word(0); a1 = model_word(1);
      in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      rand_beat();
      b0 = model_word(0); b1 = model_word(1);
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (out_valid !== 1'b1 || out_idx !== 1'b0 || out_last !== 1'b0 || out_data !== a0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_stall%0d: got v=%b idx=%0d last=%b rdy=%b data=%h want v=1 idx=0 last=0 rdy=0 data=%h", i, out_valid, out_idx, out_last, in_ready, out_data, a0);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      checks++; if (out_idx !== 1'b0 || out_data !== a0 || in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_release0: got idx=%0d rdy=%b data=%h want idx=0 rdy=0 data=%h", out_idx, in_ready, out_data, a0);
      end
      @(negedge clk); #1;
      checks++; if (out_idx !== 1'b1 || out_last !== 1'b1 || out_data !== a1 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release1: got idx=%0d last=%b rdy=%b data=%h want idx=1 last=1 rdy=1 data=%h", out_idx, out_last, in_ready, out_data, a1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1 || out_idx !== 1'b0 || out_data !== b0) begin
         errors++; $display("FAIL bp_second0: got v=%b idx=%0d data=%h want v=1 idx=0 data=%h", out_valid, out_idx, out_data, b0);
      end
      @(negedge clk); #1;
      checks++; if (out_idx !== 1'b1 || out_data !== b1) begin
         errors++; $display("FAIL bp_second1: got idx=%0d data=%h want idx=1 data=%h", out_idx, out_data, b1);
      end
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      int n_beats, words, gaps;
      logic started, exp_v, exp_rdy, hs, acc;
      n_beats = 0; words = 0; gaps = 0; started = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rand_beat(); in_valid = 1'b1; out_ready = 1'b1; n_beats = 1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         #1;
         exp_v   = (exp_q.size() != 0);
         exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
         if (out_valid === 1'b1) started = 1'b1;
         if (started && words < 20 && out_valid !== 1'b1) gaps++;
         checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL b2b_valid c%0d: got %b want %b", cyc, out_valid, exp_v); end
         checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL b2b_in_ready c%0d: got %b want %b", cyc, in_ready, exp_rdy); end
         if (exp_v && out_valid === 1'b1) begin
            checks++;
            if (out_data !== exp_q[0].data || int'(out_idx) !== exp_q[0].idx || out_sat !== exp_q[0].sat || out_last !== (exp_q[0].idx == W-1)) begin
               errors++; $display("FAIL b2b_word c%0d: got data=%h idx=%0d sat=%b last=%b want data=%h idx=%0d sat=%b", cyc, out_data, out_idx, out_sat, out_last, exp_q[0].data, exp_q[0].idx, exp_q[0].sat);
            end
         end
         hs  = exp_v && out_ready;
         acc = in_valid && exp_rdy;
         if (hs) begin void'(exp_q.pop_front()); words++; end
         if (acc) push_expected();
         if (n_beats == 10 && !in_valid && exp_q.size() == 0) break;
         @(negedge clk);
         if (acc) begin
            if (n_beats < 10) begin rand_beat(); n_beats++; end
            else in_valid = 1'b0;
         end
      end
      checks++; if (words !== 20) begin errors++; $display("FAIL b2b_count: got %0d words want 20", words); end
      checks++; if (gaps !== 0)   begin errors++; $display("FAIL b2b_gaps: got %0d gap cycles want 0", gaps); end
   endtask

   task automatic test_reset_mid_send();
      @(negedge clk);
      rand_beat(); in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1 || out_idx !== 1'b0) begin errors++; $display("FAIL rms_word0: got v=%b idx=%0d want v=1 idx=0", out_valid, out_idx); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rms_after_reset: got %b want 0", out_valid); end
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rms_quiet%0d: got v=%b rdy=%b want v=0 rdy=1", i, out_valid, in_ready); end
         @(negedge clk); #1;
      end
   endtask

   task automatic test_random();
      int beats, words;
      logic pending, exp_v, exp_rdy, hs, acc;
      beats = 0; words = 0; pending = 1'b0;
      exp_q.delete();
      for (int cyc = 0; cyc < 30000; cyc++) begin
         @(negedge clk);
         if (!pending && beats < 1000 && $urandom_range(0, 1) == 1) begin
            rand_beat(); in_valid = 1'b1; pending = 1'b1; beats++;
         end else if (!pending) begin
            in_valid = 1'b0;
         end
         out_ready = (beats >= 1000 && !pending) ? 1'b1 : 1'($urandom_range(0, 1));
         #1;
         exp_v   = (exp_q.size() != 0);
         exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
         checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, out_valid, exp_v); end
         checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready c%0d: got %b want %b", cyc, in_ready, exp_rdy); end
         if (exp_v && out_valid === 1'b1) begin
            checks++;
            if (out_data !== exp_q[0].data || int'(out_idx) !== exp_q[0].idx || out_sat !== exp_q[0].sat || out_last !== (exp_q[0].idx == W-1)) begin
               errors++; $display("FAIL rnd_word c%0d: got data=%h idx=%0d sat=%b last=%b want data=%h idx=%0d sat=%b", cyc, out_data, out_idx, out_sat, out_last, exp_q[0].data, exp_q[0].idx, exp_q[0].sat);
            end
         end
         hs  = exp_v && out_ready;
         acc = in_valid && exp_rdy;
         if (hs) begin void'(exp_q.pop_front()); words++; end
         if (acc) begin push_expected(); pending = 1'b0; end
         if (beats >= 1000 && !pending && exp_q.size() == 0) break;
      end
      in_valid = 1'b0;
      checks++; if (beats !== 1000 || pending) begin errors++; $display("FAIL rnd_beats: got %0d beats pending=%b want 1000 pending=0", beats, pending); end
      checks++; if (words !== 2 * beats || exp_q.size() != 0) begin errors++; $display("FAIL rnd_words: got %0d words left=%0d want %0d left=0", words, exp_q.size(), 2 * beats); end
   endtask

   initial begin
      for (int w = 0; w < W; w++) in_shifted[w] = '0;
      test_reset();
      test_ramp();
      test_saturation();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_send();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
